uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of requester channels (2..8).
REQ-002 The block SHALL have parameter TAG_EN, default 1; when 1, a channel tag byte precedes data on every channel switch.
REQ-003 The block SHALL have parameter TAG_BASE, default 8'hF0; the tag byte for channel i is TAG_BASE | i.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port req_valid, input, NUM_CH bits: bit i high means channel i has a byte pending.
REQ-007 The block SHALL have port req_data, input, 8*NUM_CH bits: the byte for channel i is req_data[8*i+7:8*i].
REQ-008 The block SHALL have port req_ready, output, NUM_CH bits: a one-cycle pulse on bit i means channel i's byte was accepted.
REQ-009 The block SHALL have port tx_data, output, 8 bits: the byte presented to uart_tx.
REQ-010 The block SHALL have port tx_start, output, 1 bit: a one-cycle start pulse to uart_tx (its data_ready input).
REQ-011 The block SHALL have port tx_done, input, 1 bit: the uart_tx done flag, which is low during a frame and high once the stop bit completes.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 The block SHALL have port cur_ch, output, 3 bits: the most recently granted channel.

Function
REQ-014 The state machine SHALL have exactly the states IDLE, WAIT_TAG and WAIT_DATA.
REQ-015 Completion SHALL be detected only on a tx_done rising edge (tx_done high while registered tx_done_q is low); a stale high level SHALL never count as completion.
REQ-016 In IDLE with any req_valid bit high, the block SHALL pick grant g by round-robin, searching from cur_ch+1 upward with wrap from NUM_CH-1 to 0.
REQ-017 On the grant edge, the block SHALL latch req_data for g into an internal byte register, set cur_ch=g, and register req_ready[g]=1 for exactly the next cycle.
REQ-018 On the grant edge with TAG_EN=1 and (tag_valid=0 or g != tag_ch), the block SHALL register tx_data=TAG_BASE|g and tx_start=1, set tag_ch=g and tag_valid=1, and go to WAIT_TAG.
REQ-019 On the grant edge when no tag is needed, the block SHALL register tx_data=latched byte and tx_start=1, then go to WAIT_DATA.
REQ-020 Grant-to-start latency SHALL be one cycle: req_ready[g] and tx_start assert in the same cycle, the first after req_valid is sampled.
REQ-021 In WAIT_TAG on a tx_done rise, the block SHALL register tx_data=latched byte and tx_start=1, then go to WAIT_DATA.
REQ-022 In WAIT_DATA on a tx_done rise, the block SHALL go to IDLE, with arbitration possible on the immediately following edge.
REQ-023 tx_start SHALL be high for exactly one cycle per byte; tx_data SHALL hold its value until the next start.
REQ-024 req_valid and req_data SHALL be sampled only on a grant edge; changes at any other time SHALL have no effect.
REQ-025 At most one req_ready bit SHALL be high in any cycle, and never outside the cycle after a grant.
REQ-026 A channel granted twice in succession SHALL not receive a second tag.

Reset
REQ-027 When rst_n is low, the block SHALL immediately force state=IDLE, tx_start=0, tx_data=8'h00, req_ready=0, busy=0, cur_ch=NUM_CH-1, tag_valid=0, tag_ch=0 and tx_done_q=0.
REQ-028 On reset mid-frame, the block SHALL discard the latched byte without further req_ready, and the first grant after release SHALL emit a tag (TAG_EN=1).

Verification
REQ-029 The bench SHALL cover: reset release, ch0 valid with 8'hA5 -> tx bytes F0 then A5, req_ready[0] one pulse, busy falls after second done.
REQ-030 The bench SHALL cover: ch0 sends 8'h11 then 8'h22 back-to-back -> tx sequence F0,11,22 with no repeated tag.
REQ-031 The bench SHALL cover: all four channels valid together after reset -> order ch0,ch1,ch2,ch3, each byte preceded by F0..F3 respectively.
REQ-032 The bench SHALL cover: tx_done held high from a prior frame when tx_start fires -> no advance until done falls and rises again.
REQ-033 The bench SHALL cover: rst_n pulsed low during WAIT_DATA -> tx_start=0 and busy=0 at once, and the next ch0 byte is re-tagged F0.
REQ-034 The bench SHALL cover: TAG_EN=0 with ch2 8'h3C then ch1 8'h7E -> tx bytes 3C,7E only, with cur_ch tracking 2 then 1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds bytes from several requester channels into one uart_tx.
// It can prefix a channel tag byte whenever the granted channel differs from the last tagged one.
module uart_tx_arbiter #(
  parameter int          NUM_CH   = 4,
  parameter int          TAG_EN   = 1,
  parameter logic [7:0]  TAG_BASE = 8'hF0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     req_valid,
  input  logic [8*NUM_CH-1:0]   req_data,
  output logic [NUM_CH-1:0]     req_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_done,
  output logic                  busy,
  output logic [2:0]            cur_ch
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_TAG  = 2'd1;
  localparam logic [1:0] WAIT_DATA = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [7:0]        byte_q, byte_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic [NUM_CH-1:0] req_ready_q, req_ready_d;
  logic [2:0]        cur_ch_q, cur_ch_d;
  logic              tag_valid_q, tag_valid_d;
  logic [2:0]        tag_ch_q, tag_ch_d;
  logic              tx_done_q;

  logic              done_rise;
  logic [7:0]        valid_ext;
  logic [7:0]        ch_byte [8];
  logic              grant_found;
  logic [2:0]        grant_ch;
  logic [2:0]        scan_idx;

  // Channels are widened to a fixed 8-entry view so a 3-bit channel number can index them directly.
  assign valid_ext = 8'(req_valid);

  for (genvar i = 0; i < 8; i++) begin : g_bytes
    if (i < NUM_CH) begin : g_live
      assign ch_byte[i] = req_data[8*i +: 8];
    end else begin : g_pad
      assign ch_byte[i] = 8'h00;
    end
  end

  assign done_rise = tx_done & ~tx_done_q;

  // Search starts one past the last grant so every channel gets a fair turn.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = 3'd0;
    scan_idx    = 3'd0;
    for (int k = 1; k <= NUM_CH; k++) begin
      scan_idx = 3'((int'(cur_ch_q) + k) % NUM_CH);
      if (!grant_found && valid_ext[scan_idx]) begin
        grant_found = 1'b1;
        grant_ch    = scan_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    req_ready_d = '0;
    cur_ch_d    = cur_ch_q;
    tag_valid_d = tag_valid_q;
    tag_ch_d    = tag_ch_q;

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          byte_d     = ch_byte[grant_ch];
          cur_ch_d   = grant_ch;
          tx_start_d = 1'b1;
          for (int i = 0; i < NUM_CH; i++) begin
            if (grant_ch == 3'(i)) req_ready_d[i] = 1'b1;
          end
          if ((TAG_EN != 0) && (!tag_valid_q || (grant_ch != tag_ch_q))) begin
            tx_data_d   = TAG_BASE | {5'b00000, grant_ch};
            tag_ch_d    = grant_ch;
            tag_valid_d = 1'b1;
            state_d     = WAIT_TAG;
          end else begin
            tx_data_d = ch_byte[grant_ch];
            state_d   = WAIT_DATA;
          end
        end
      end
      WAIT_TAG: begin
        if (done_rise) begin
          tx_data_d  = byte_q;
          tx_start_d = 1'b1;
          state_d    = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (done_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      byte_q      <= 8'h00;
      tx_data_q   <= 8'h00;
      tx_start_q  <= 1'b0;
      req_ready_q <= '0;
      cur_ch_q    <= 3'(NUM_CH - 1);
      tag_valid_q <= 1'b0;
      tag_ch_q    <= 3'd0;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      req_ready_q <= req_ready_d;
      cur_ch_q    <= cur_ch_d;
      tag_valid_q <= tag_valid_d;
      tag_ch_q    <= tag_ch_d;
      tx_done_q   <= tx_done;
    end
  end

  assign req_ready = req_ready_q;
  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign busy      = (state_q != IDLE);
  assign cur_ch    = cur_ch_q;

endmodule
